ysyx_24070016_idu: RTL and testbench

YSYX_24070016_IDU -- requirements
Module: ysyx_24070016_IDU

---
 rtl/ysyx_24070016_pkg.sv | 83 ++++++++
 rtl/ysyx_24070016_idu_dec.sv | 165 ++++++++++++++++
 rtl/ysyx_24070016_idu.sv | 106 ++++++++++
 tb/tb_ysyx_24070016_idu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070016_pkg.sv
// rtl/ysyx_24070016_pkg.sv - shared opcode, ALU-op and ALU-source encodings for decode and execute
// Contents:
//   OPC_*        RV32 major opcodes (inst[6:0])
//   aluop_e      4-bit ALU operation select
//   alusrc1_e    ALU operand A select (rs1 / pc)
//   alusrc2_e    ALU operand B select (rs2 / imm / constant 4)
//   dec_t        decoded instruction bundle held by the IDU output register
//   alu_op_of()  funct3 -> ALU op mapping shared by OP and OP-IMM
package ysyx_24070016_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [6:0]  FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } aluop_e;

  typedef enum logic {
    SRC1_RS1 = 1'b0,
    SRC1_PC  = 1'b1
  } alusrc1_e;

  typedef enum logic [1:0] {
    SRC2_RS2  = 2'b00,
    SRC2_IMM  = 2'b01,
    SRC2_FOUR = 2'b10
  } alusrc2_e;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    alusrc1_e    alusrc1;
    alusrc2_e    alusrc2;
    aluop_e      aluop;
    logic        reg_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        ebreak;
    logic        illegal;
    logic [2:0]  funct3;
  } dec_t;

  // alt selects SUB/SRA on the two funct3 values that have an alternate form.
  function automatic aluop_e alu_op_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24070016_idu_dec.sv
// rtl/ysyx_24070016_idu_dec.sv - purely combinational RV32I/E instruction decoder
// Ports:
//   inst  in  32  raw instruction word
//   dec   out     decoded bundle (dec_t); enables already masked by illegal/rd==0
// Parameter RVE: 1 flags any used register index >= 16 as illegal.
module ysyx_24070016_idu_dec
  import ysyx_24070016_pkg::*;
#(
  parameter bit RVE = 1'b1
) (
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        use_rs1;
  logic        use_rs2;
  logic        use_rd;
  logic        wen;
  logic        bad;
  logic        rve_bad;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    wen     = 1'b0;
    bad     = 1'b0;
    rve_bad = 1'b0;

    dec.funct3 = funct3;

    case (opcode)
      OPC_LUI: begin
        use_rd      = 1'b1;
        wen         = 1'b1;
        dec.imm     = imm_u;
        dec.alusrc2 = SRC2_IMM;
        dec.aluop   = ALU_PASS;
      end
      OPC_AUIPC: begin
        use_rd      = 1'b1;
        wen         = 1'b1;
        dec.imm     = imm_u;
        dec.alusrc1 = SRC1_PC;
        dec.alusrc2 = SRC2_IMM;
        dec.aluop   = ALU_ADD;
      end
      // Jumps: the ALU produces the link value pc+4; the target uses imm.
      OPC_JAL: begin
        use_rd      = 1'b1;
        wen         = 1'b1;
        dec.imm     = imm_j;
        dec.alusrc1 = SRC1_PC;
        dec.alusrc2 = SRC2_FOUR;
        dec.aluop   = ALU_ADD;
        dec.is_jal  = 1'b1;
      end
      OPC_JALR: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        wen         = 1'b1;
        dec.imm     = imm_i;
        dec.alusrc1 = SRC1_PC;
        dec.alusrc2 = SRC2_FOUR;
        dec.aluop   = ALU_ADD;
        dec.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.imm       = imm_b;
        dec.is_branch = 1'b1;
        case (funct3[2:1])
          2'b10:   dec.aluop = ALU_SLT;
          2'b11:   dec.aluop = ALU_SLTU;
          default: dec.aluop = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        wen         = 1'b1;
        dec.imm     = imm_i;
        dec.alusrc2 = SRC2_IMM;
        dec.mem_ren = 1'b1;
      end
      OPC_STORE: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec.imm     = imm_s;
        dec.alusrc2 = SRC2_IMM;
        dec.mem_wen = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rs1     = 1'b1;
        use_rd      = 1'b1;
        wen         = 1'b1;
        dec.imm     = imm_i;
        dec.alusrc2 = SRC2_IMM;
        // Only the shift forms carry a funct7 field; ADDI etc. use all 12 bits as imm.
        dec.aluop   = alu_op_of(funct3, (funct3 == 3'b101) && funct7[5]);
        if (funct3 == 3'b001)
          bad = (funct7 != 7'b0);
        else if (funct3 == 3'b101)
          bad = (funct7 != 7'b0) && (funct7 != FUNCT7_ALT);
      end
      OPC_OP: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rd    = 1'b1;
        wen       = 1'b1;
        dec.aluop = alu_op_of(funct3, funct7[5]);
        if (funct7 == FUNCT7_ALT)
          bad = (funct3 != 3'b000) && (funct3 != 3'b101);
        else
          bad = (funct7 != 7'b0);
      end
      OPC_SYSTEM: begin
        if (inst == INST_EBREAK)
          dec.ebreak = 1'b1;
        else
          bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    // Only fields the format actually uses are checked, so LUI/JAL immediate
    // bits that overlap rs1/rs2 never trip the RVE range check.
    rve_bad = RVE && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));

    dec.rs1     = use_rs1 ? rs1 : 5'd0;
    dec.rs2     = use_rs2 ? rs2 : 5'd0;
    dec.rd      = use_rd  ? rd  : 5'd0;
    dec.illegal = bad || rve_bad;
    dec.reg_wen = wen && (dec.rd != 5'd0) && !dec.illegal;
    dec.mem_ren = dec.mem_ren && !dec.illegal;
    dec.mem_wen = dec.mem_wen && !dec.illegal;
  end

endmodule

// File: rtl/ysyx_24070016_idu.sv
// rtl/ysyx_24070016_idu.sv - instruction decode unit: one-entry handshake register around the decoder
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready/in_inst/in_pc     fetch-side handshake
//   flush                               drop held entry and any same-cycle capture
//   out_valid/out_ready                 execute-side handshake
//   out_pc/out_imm/out_rs1/out_rs2/out_rd, sel_alusrc1/2, sel_aluop,
//   reg_wen/mem_ren/mem_wen/is_branch/is_jal/is_jalr/ebreak/illegal/funct3
//                                       registered decode results
module ysyx_24070016_idu
  import ysyx_24070016_pkg::*;
#(
  parameter bit RVE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        sel_alusrc1,
  output logic [1:0]  sel_alusrc2,
  output logic [3:0]  sel_aluop,
  output logic        reg_wen,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        ebreak,
  output logic        illegal,
  output logic [2:0]  funct3
);

  dec_t        dec_w;
  dec_t        ent_d;
  dec_t        ent_q;
  logic [31:0] pc_d;
  logic [31:0] pc_q;
  logic        valid_d;
  logic        valid_q;
  logic        fire;

  ysyx_24070016_idu_dec #(.RVE(RVE)) u_dec (
    .inst (in_inst),
    .dec  (dec_w)
  );

  assign in_ready = !valid_q || out_ready;
  assign fire     = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (fire) begin
      valid_d = 1'b1;
      ent_d   = dec_w;
      pc_d    = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_imm     = ent_q.imm;
  assign out_rs1     = ent_q.rs1;
  assign out_rs2     = ent_q.rs2;
  assign out_rd      = ent_q.rd;
  assign sel_alusrc1 = ent_q.alusrc1;
  assign sel_alusrc2 = ent_q.alusrc2;
  assign sel_aluop   = ent_q.aluop;
  assign reg_wen     = ent_q.reg_wen;
  assign mem_ren     = ent_q.mem_ren;
  assign mem_wen     = ent_q.mem_wen;
  assign is_branch   = ent_q.is_branch;
  assign is_jal      = ent_q.is_jal;
  assign is_jalr     = ent_q.is_jalr;
  assign ebreak      = ent_q.ebreak;
  assign illegal     = ent_q.illegal;
  assign funct3      = ent_q.funct3;

endmodule

// File: tb/tb_ysyx_24070016_idu.sv
// tb/tb_ysyx_24070016_idu.sv - directed self-checking bench for ysyx_24070016_idu
module tb_ysyx_24070016_idu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic        sel_alusrc1;
  logic [1:0]  sel_alusrc2;
  logic [3:0]  sel_aluop;
  logic        reg_wen;
  logic        mem_ren;
  logic        mem_wen;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        ebreak;
  logic        illegal;
  logic [2:0]  funct3;

  int tests = 0;
  int fails = 0;

  ysyx_24070016_idu #(.RVE(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .sel_alusrc1 (sel_alusrc1),
    .sel_alusrc2 (sel_alusrc2),
    .sel_aluop   (sel_aluop),
    .reg_wen     (reg_wen),
    .mem_ren     (mem_ren),
    .mem_wen     (mem_wen),
    .is_branch   (is_branch),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .ebreak      (ebreak),
    .illegal     (illegal),
    .funct3      (funct3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    in_pc     = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_imm",       out_imm,        32'd0);
    chk("rst_reg_wen",   32'(reg_wen),   32'd0);

    // ADDI x1,x0,5 on the first edge after reset release
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h0050_0093;
    in_pc    = 32'h8000_0004;
    @(negedge clk);
    chk("addi_valid",   32'(out_valid),   32'd1);
    chk("addi_imm",     out_imm,          32'd5);
    chk("addi_src2",    32'(sel_alusrc2), 32'd1);
    chk("addi_aluop",   32'(sel_aluop),   32'd0);
    chk("addi_rd",      32'(out_rd),      32'd1);
    chk("addi_reg_wen", 32'(reg_wen),     32'd1);
    chk("addi_pc",      out_pc,           32'h8000_0004);

    // AUIPC x2,0x12345
    in_inst = 32'h1234_5117;
    in_pc   = 32'h8000_0000;
    @(negedge clk);
    chk("auipc_imm",  out_imm,          32'h1234_5000);
    chk("auipc_src1", 32'(sel_alusrc1), 32'd1);
    chk("auipc_pc",   out_pc,           32'h8000_0000);
    chk("auipc_rd",   32'(out_rd),      32'd2);

    // JAL x1,-4
    in_inst = 32'hFFDF_F0EF;
    @(negedge clk);
    chk("jal_imm",     out_imm,          32'hFFFF_FFFC);
    chk("jal_src1",    32'(sel_alusrc1), 32'd1);
    chk("jal_src2",    32'(sel_alusrc2), 32'd2);
    chk("jal_is_jal",  32'(is_jal),      32'd1);
    chk("jal_reg_wen", 32'(reg_wen),     32'd1);

    // SUB x3,x1,x2
    in_inst = 32'h4020_81B3;
    @(negedge clk);
    chk("sub_aluop", 32'(sel_aluop),   32'd1);
    chk("sub_src2",  32'(sel_alusrc2), 32'd0);
    chk("sub_rs1",   32'(out_rs1),     32'd1);
    chk("sub_rs2",   32'(out_rs2),     32'd2);
    chk("sub_rd",    32'(out_rd),      32'd3);

    // SW x2,8(x1)
    in_inst = 32'h0020_A423;
    @(negedge clk);
    chk("sw_mem_wen", 32'(mem_wen), 32'd1);
    chk("sw_reg_wen", 32'(reg_wen), 32'd0);
    chk("sw_imm",     out_imm,      32'd8);
    chk("sw_funct3",  32'(funct3),  32'd2);

    // ADDI x0,x0,5 : rd = 0 suppresses the write
    in_inst = 32'h0050_0013;
    @(negedge clk);
    chk("addi_x0_reg_wen", 32'(reg_wen), 32'd0);
    chk("addi_x0_illegal", 32'(illegal), 32'd0);

    // EBREAK
    in_inst = 32'h0010_0073;
    @(negedge clk);
    chk("ebreak_flag",    32'(ebreak),  32'd1);
    chk("ebreak_reg_wen", 32'(reg_wen), 32'd0);
    chk("ebreak_illegal", 32'(illegal), 32'd0);

    // All-ones word
    in_inst = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("ones_illegal", 32'(illegal), 32'd1);
    chk("ones_reg_wen", 32'(reg_wen), 32'd0);
    chk("ones_mem_ren", 32'(mem_ren), 32'd0);
    chk("ones_mem_wen", 32'(mem_wen), 32'd0);

    // ADD x20,x1,x2 under RVE
    in_inst = 32'h0020_8A33;
    @(negedge clk);
    chk("rve_illegal", 32'(illegal), 32'd1);
    chk("rve_reg_wen", 32'(reg_wen), 32'd0);

    // Drain
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: ADDI captured, LUI waits while out_ready is low
    in_valid  = 1'b1;
    in_inst   = 32'h0050_0093;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_valid0",    32'(out_valid), 32'd1);
    chk("bp_in_ready0", 32'(in_ready),  32'd0);
    chk("bp_imm0",      out_imm,        32'd5);
    in_inst = 32'hABCD_E2B7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_hold_valid",    32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready),  32'd0);
      chk("bp_hold_imm",      out_imm,        32'd5);
      chk("bp_hold_rd",       32'(out_rd),    32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_lui_imm",   out_imm,          32'hABCD_E000);
    chk("bp_lui_aluop", 32'(sel_aluop),   32'd10);
    chk("bp_lui_rd",    32'(out_rd),      32'd5);
    chk("bp_lui_src2",  32'(sel_alusrc2), 32'd1);

    // Flush beats a same-cycle capture
    in_valid = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    in_inst  = 32'h0050_0093;
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;

    // Asynchronous reset while an entry is held
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(out_valid), 32'd0);
    chk("arst_imm",      out_imm,        32'd0);
    chk("arst_in_ready", 32'(in_ready),  32'd1);
    chk("arst_reg_wen",  32'(reg_wen),   32'd0);

    // Accept on the first edge after release
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h1234_5117;
    in_pc     = 32'h8000_0000;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_imm",   out_imm,        32'h1234_5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
